// File: rtl/fill_cmd_if.sv
// Command and fill-block handshake bundle for fill_cmd_sequencer.
// slave = sequencer view, master = upstream command source plus fill block.
interface fill_cmd_if #(parameter int ROW_W = 12);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [47:0]      cmd_coordinates;
  logic [23:0]      cmd_color;
  logic             cmd_layer;
  logic             cmd_fill_type;
  logic [1:0]       cmd_texture;
  logic [47:0]      coordinates;
  logic [23:0]      color_code;
  logic             layer_num;
  logic             fill_type;
  logic [1:0]       texture_code;
  logic             math_start;
  logic             row_start;
  logic             fill_start;
  logic             fill_done;
  logic             all_finish;
  logic             busy;
  logic             cmd_done;
  logic [ROW_W-1:0] row_count;
  logic             timeout_err;

  modport slave (
    input  cmd_valid, cmd_coordinates, cmd_color, cmd_layer, cmd_fill_type, cmd_texture,
           fill_done, all_finish,
    output cmd_ready, coordinates, color_code, layer_num, fill_type, texture_code,
           math_start, row_start, fill_start, busy, cmd_done, row_count, timeout_err
  );

  modport master (
    output cmd_valid, cmd_coordinates, cmd_color, cmd_layer, cmd_fill_type, cmd_texture,
           fill_done, all_finish,
    input  cmd_ready, coordinates, color_code, layer_num, fill_type, texture_code,
           math_start, row_start, fill_start, busy, cmd_done, row_count, timeout_err
  );
endinterface

// File: rtl/fill_cmd_sequencer.sv
// Buffers draw commands and sequences math/row/fill strobes into the fill block,
// one command at a time, retiring on all_finish, row-count saturation or timeout.
module fill_cmd_sequencer #(
  parameter int CMD_DEPTH    = 4,
  parameter int MATH_SETTLE  = 2,
  parameter int FILL_TIMEOUT = 255,
  parameter int ROW_W        = 12
) (
  input  logic      clk,
  input  logic      rst,
  fill_cmd_if.slave bus
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (MATH_SETTLE > 1) ? $clog2(MATH_SETTLE) : 1;
  localparam int TW = $clog2(FILL_TIMEOUT + 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_MATH   = 4'd2;
  localparam logic [3:0] S_SETTLE = 4'd3;
  localparam logic [3:0] S_ROW    = 4'd4;
  localparam logic [3:0] S_GAP    = 4'd5;
  localparam logic [3:0] S_FILL   = 4'd6;
  localparam logic [3:0] S_WAIT   = 4'd7;
  localparam logic [3:0] S_RETIRE = 4'd8;

  typedef struct packed {
    logic [47:0] coord;
    logic [23:0] color;
    logic        layer;
    logic        ftype;
    logic [1:0]  tex;
  } cmd_t;

  cmd_t             mem_q [CMD_DEPTH];
  cmd_t             stage_q, stage_d, held_q, held_d, wr_entry;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [3:0]       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [ROW_W-1:0] row_q, row_d, row_inc;
  logic             terr_q, terr_d;
  logic             push, pop;

  assign wr_entry = '{coord: bus.cmd_coordinates, color: bus.cmd_color, layer: bus.cmd_layer,
                      ftype: bus.cmd_fill_type, tex: bus.cmd_texture};

  // cmd_ready is registered from the next count, so a full FIFO refuses even on a pop cycle
  always_comb begin
    push        = bus.cmd_valid && cmd_ready_q;
    pop         = (state_q == S_IDLE) && (count_q != '0);
    count_d     = count_q + CW'(push) - CW'(pop);
    cmd_ready_d = (count_d != CW'(CMD_DEPTH));
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    held_d   = held_q;
    row_d    = row_q;
    settle_d = settle_q;
    wait_d   = wait_q;
    terr_d   = terr_q;
    row_inc  = row_q + ROW_W'(1);
    case (state_q)
      S_IDLE: if (pop) begin
        stage_d = mem_q[rd_ptr_q];
        state_d = S_LOAD;
      end
      S_LOAD: begin
        held_d  = stage_q;
        row_d   = '0;
        state_d = S_MATH;
      end
      S_MATH: begin
        settle_d = '0;
        state_d  = (MATH_SETTLE == 0) ? S_ROW : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SW'(MATH_SETTLE - 1)) state_d = S_ROW;
        else                                  settle_d = settle_q + SW'(1);
      end
      S_ROW:  state_d = S_GAP;
      S_GAP:  state_d = S_FILL;
      S_FILL: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fill_done) begin
          row_d   = row_inc;
          state_d = (bus.all_finish || row_inc == '1) ? S_RETIRE : S_ROW;
        end else if (wait_q == TW'(FILL_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_RETIRE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      state_q     <= S_IDLE;
      stage_q     <= '0;
      held_q      <= '0;
      row_q       <= '0;
      settle_q    <= '0;
      wait_q      <= '0;
      terr_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      state_q     <= state_d;
      stage_q     <= stage_d;
      held_q      <= held_d;
      row_q       <= row_d;
      settle_q    <= settle_d;
      wait_q      <= wait_d;
      terr_q      <= terr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Strobes decode straight from state so reset drops them asynchronously
  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.coordinates  = held_q.coord;
  assign bus.color_code   = held_q.color;
  assign bus.layer_num    = held_q.layer;
  assign bus.fill_type    = held_q.ftype;
  assign bus.texture_code = held_q.tex;
  assign bus.math_start   = (state_q == S_MATH);
  assign bus.row_start    = (state_q == S_ROW);
  assign bus.fill_start   = (state_q == S_FILL);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.cmd_done     = (state_q == S_RETIRE);
  assign bus.row_count    = row_q;
  assign bus.timeout_err  = terr_q;
endmodule

// File: tb/tb_fill_cmd_sequencer.sv
// Directed bench for fill_cmd_sequencer: reset, single command, FIFO full/order/wrap,
// timeout abort and mid-command reset, with a reactive fill-block model.
module tb_fill_cmd_sequencer;
  localparam int ROW_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fill_cmd_if #(.ROW_W(ROW_W)) bus ();

  fill_cmd_sequencer #(.CMD_DEPTH(4), .MATH_SETTLE(2), .FILL_TIMEOUT(255), .ROW_W(ROW_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Fill-block model: fill_done 10 cycles after each fill_start; all_finish on row finish_row
  int model_en = 0;
  int finish_row = 1;
  int dly = 0;
  int rows_done = 0;
  always @(negedge clk) begin
    bus.fill_done  = 1'b0;
    bus.all_finish = 1'b0;
    if (rst) begin
      dly       = 0;
      rows_done = 0;
    end else begin
      if (bus.math_start) rows_done = 0;
      if (dly > 0) begin
        dly = dly - 1;
        if (dly == 0) begin
          bus.fill_done  = 1'b1;
          rows_done      = rows_done + 1;
          bus.all_finish = (rows_done >= finish_row);
        end
      end
      if (bus.fill_start && model_en != 0) dly = 10;
    end
  end

  int n_math, n_row, n_fill, n_done, hold_bad, step_no;
  int first_math, first_row, first_fill, done_step;
  logic [23:0]      done_col[$];
  logic [ROW_W-1:0] last_rowcnt;
  logic             last_terr, terr_before, terr_prev;
  logic             hold_en = 1'b0;
  logic [47:0]      hold_coord = '0;
  logic [23:0]      hold_col = '0;

  task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task clr();
    n_math = 0; n_row = 0; n_fill = 0; n_done = 0; hold_bad = 0; step_no = 0;
    first_math = -1; first_row = -1; first_fill = -1; done_step = -1;
    done_col.delete();
    last_rowcnt = '0; last_terr = 1'b0; terr_before = 1'b0; terr_prev = bus.timeout_err;
  endtask

  task step();
    @(negedge clk);
    step_no++;
    if (bus.math_start) begin n_math++; if (first_math < 0) first_math = step_no; end
    if (bus.row_start)  begin n_row++;  if (first_row  < 0) first_row  = step_no; end
    if (bus.fill_start) begin n_fill++; if (first_fill < 0) first_fill = step_no; end
    if (bus.cmd_done) begin
      n_done++;
      done_col.push_back(bus.color_code);
      last_rowcnt = bus.row_count;
      last_terr   = bus.timeout_err;
      terr_before = terr_prev;
      done_step   = step_no;
    end
    if (hold_en && n_math > 0 && bus.busy &&
        (bus.coordinates !== hold_coord || bus.color_code !== hold_col)) hold_bad++;
    terr_prev = bus.timeout_err;
  endtask

  task push_cmd(input logic [47:0] c, input logic [23:0] col, input logic lay);
    bus.cmd_valid       = 1'b1;
    bus.cmd_coordinates = c;
    bus.cmd_color       = col;
    bus.cmd_layer       = lay;
    bus.cmd_fill_type   = 1'b0;
    bus.cmd_texture     = 2'b01;
    step();
    bus.cmd_valid       = 1'b0;
  endtask

  task wait_done(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (n_done < target && b > 0) begin step(); b--; end
    chk(tag, 64'(n_done), 64'(target));
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_coordinates = '0; bus.cmd_color = '0; bus.cmd_layer = 1'b0;
    bus.cmd_fill_type = 1'b0; bus.cmd_texture = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_strobes", 64'({bus.math_start, bus.row_start, bus.fill_start, bus.cmd_done}), 64'd0);
    chk("rst_coord", 64'(bus.coordinates), 64'd0);
    chk("rst_color", 64'(bus.color_code), 64'd0);
    chk("rst_terr", 64'(bus.timeout_err), 64'd0);
    chk("rst_rowcnt", 64'(bus.row_count), 64'd0);

    // Single command, five rows
    clr();
    model_en = 1; finish_row = 5;
    hold_en = 1'b1; hold_coord = 48'h0C80C80CCCCC; hold_col = 24'hFF0000;
    push_cmd(48'h0C80C80CCCCC, 24'hFF0000, 1'b0);
    wait_done("single_done", 1, 400);
    repeat (20) step();
    hold_en = 1'b0;
    chk("single_first_math", 64'(first_math), 64'd3);
    chk("single_first_row", 64'(first_row), 64'd6);
    chk("single_first_fill", 64'(first_fill), 64'd8);
    chk("single_n_math", 64'(n_math), 64'd1);
    chk("single_n_row", 64'(n_row), 64'd5);
    chk("single_n_fill", 64'(n_fill), 64'd5);
    chk("single_n_done", 64'(n_done), 64'd1);
    chk("single_rowcnt", 64'(last_rowcnt), 64'd5);
    chk("single_hold", 64'(hold_bad), 64'd0);
    chk("single_coord_idle", 64'(bus.coordinates), 64'h0C80C80CCCCC);
    chk("single_layer", 64'(bus.layer_num), 64'd0);
    chk("single_tex", 64'(bus.texture_code), 64'd1);
    chk("single_terr", 64'(bus.timeout_err), 64'd0);
    chk("single_busy", 64'(bus.busy), 64'd0);

    // Back-to-back: A in flight, B..E fill the FIFO, F refused
    clr();
    finish_row = 1;
    push_cmd(48'h1, 24'h000001, 1'b1);
    repeat (3) step();
    push_cmd(48'h2, 24'h000002, 1'b0);
    push_cmd(48'h3, 24'h000003, 1'b0);
    push_cmd(48'h4, 24'h000004, 1'b0);
    chk("b2b_ready_3", 64'(bus.cmd_ready), 64'd1);
    push_cmd(48'h5, 24'h000005, 1'b0);
    chk("b2b_ready_full", 64'(bus.cmd_ready), 64'd0);
    bus.cmd_valid = 1'b1; bus.cmd_color = 24'h000006;
    step(); step();
    bus.cmd_valid = 1'b0;
    chk("b2b_ready_refuse", 64'(bus.cmd_ready), 64'd0);
    wait_done("b2b_done", 5, 600);
    repeat (40) step();
    chk("b2b_no_extra", 64'(n_done), 64'd5);
    chk("b2b_n_math", 64'(n_math), 64'd5);
    for (int i = 0; i < 5 && i < done_col.size(); i++)
      chk($sformatf("b2b_order%0d", i), 64'(done_col[i]), 64'(i + 1));

    // Push and pop on the same edge at count 2, across pointer wrap
    clr();
    push_cmd(48'h10, 24'h000010, 1'b0);
    repeat (3) step();
    push_cmd(48'h11, 24'h000011, 1'b0);
    push_cmd(48'h12, 24'h000012, 1'b0);
    wait_done("wrap_first", 1, 200);
    step();
    push_cmd(48'h13, 24'h000013, 1'b0);
    chk("wrap_ready_pp", 64'(bus.cmd_ready), 64'd1);
    push_cmd(48'h14, 24'h000014, 1'b0);
    chk("wrap_ready_3", 64'(bus.cmd_ready), 64'd1);
    push_cmd(48'h15, 24'h000015, 1'b0);
    chk("wrap_ready_full", 64'(bus.cmd_ready), 64'd0);
    wait_done("wrap_done", 6, 600);
    for (int i = 0; i < 6 && i < done_col.size(); i++)
      chk($sformatf("wrap_order%0d", i), 64'(done_col[i]), 64'(24'h10 + i));

    // Timeout: no fill_done for the first command, the second completes
    clr();
    model_en = 0;
    push_cmd(48'h20, 24'h000020, 1'b0);
    push_cmd(48'h21, 24'h000021, 1'b0);
    wait_done("to_first", 1, 500);
    model_en = 1; finish_row = 1;
    chk("to_latency", 64'(done_step - first_fill), 64'd256);
    chk("to_terr_before", 64'(terr_before), 64'd0);
    chk("to_terr_set", 64'(last_terr), 64'd1);
    chk("to_rowcnt", 64'(last_rowcnt), 64'd0);
    wait_done("to_next", 2, 200);
    if (done_col.size() > 1) chk("to_next_color", 64'(done_col[1]), 64'h21);
    chk("to_next_rowcnt", 64'(last_rowcnt), 64'd1);
    chk("to_sticky", 64'(bus.timeout_err), 64'd1);

    // Reset while in WAIT with three commands queued
    clr();
    model_en = 0;
    push_cmd(48'h30, 24'h000030, 1'b0);
    push_cmd(48'h31, 24'h000031, 1'b0);
    push_cmd(48'h32, 24'h000032, 1'b0);
    push_cmd(48'h33, 24'h000033, 1'b0);
    repeat (15) step();
    chk("mid_busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_strobes", 64'({bus.math_start, bus.row_start, bus.fill_start, bus.cmd_done}), 64'd0);
    chk("mid_busy", 64'(bus.busy), 64'd0);
    chk("mid_ready", 64'(bus.cmd_ready), 64'd1);
    chk("mid_terr", 64'(bus.timeout_err), 64'd0);
    chk("mid_coord", 64'(bus.coordinates), 64'd0);
    chk("mid_rowcnt", 64'(bus.row_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (50) step();
    chk("mid_no_done", 64'(n_done), 64'd0);
    chk("mid_no_math", 64'(n_math), 64'd0);
    chk("mid_idle", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
